hist_clip_cdf: RTL

Post-frame stage downstream of the per-tile histogram accumulator in the CLAHE pipeline. After a frame completes, it walks the 16 tile histograms (4×4 tiles) of the idle ping-pong bank (`area_flag`). For each tile it clip-limits the bins, redistributes the excess evenly, forms the CDF and writes a 256-entry 8-bit mapping LUT per tile for the interpolation stage. It zeroes each histogram bin after its final read, so the bank is clean for the next frame's accumulation.

---
 rtl/hist_clip_cdf.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/hist_clip_cdf.sv
// hist_clip_cdf
// -------------
// Post-frame CLAHE stage. After a frame, walks the 16 tile histograms (4x4
// tiles, row-major) of the idle ping-pong bank. For each tile it clip-limits
// the bins, spreads the clipped excess evenly over all 256 bins, accumulates
// the CDF and writes a 256-entry 8-bit mapping LUT. Every bin is zeroed right
// after its final read, so the bank is clean for the next frame.
//
// Optional feature: CLAHE_CLIP_EN
//   defined   : CLIP pass (excess accumulation) then MAP pass per tile.
//   undefined : CLIP pass removed, clip_limit ignored, plain tiled HE.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle frame-end pulse, ignored while busy
//   area_flag             bank to process (sampled on accepted start)
//   clip_limit[15:0]      per-bin clip ceiling (sampled on accepted start)
//   tile_recip[23:0]      floor(255*2^16 / tile_pixels) (sampled on start)
//   rd_en/rd_addr/rd_block  histogram read, rd_block = {bank, row, col}
//   rd_data[15:0]         bin count, valid the cycle after rd_en
//   clr_en/clr_addr/clr_block  write-zero to a histogram bin
//   map_we/map_addr/map_block/map_data  mapping LUT write
//   busy                  sweep in progress
//   done                  one-cycle pulse after the whole sweep
//
// Histogram read handshake: there is no back-pressure. rd_en is a strobe and
// the RAM must return rd_data exactly one cycle later; the pipeline tags below
// follow the strobe through that fixed latency.

module hist_clip_cdf #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        area_flag,
  input  logic [15:0] clip_limit,
  input  logic [23:0] tile_recip,
  output logic        rd_en,
  output logic [7:0]  rd_addr,
  output logic [4:0]  rd_block,
  input  logic [15:0] rd_data,
  output logic        clr_en,
  output logic [7:0]  clr_addr,
  output logic [4:0]  clr_block,
  output logic        map_we,
  output logic [7:0]  map_addr,
  output logic [3:0]  map_block,
  output logic [7:0]  map_data,
  output logic        busy,
  output logic        done
);

  // Only a one-cycle read latency is supported.
  localparam int unused_rd_lat = RD_LAT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_MAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

`ifdef CLAHE_CLIP_EN
  localparam state_t S_FIRST = S_CLIP;
`else
  localparam state_t S_FIRST = S_MAP;
`endif

  state_t      state, state_nxt;
  logic [8:0]  cnt;        // 0..255 read slots, 256..257 drain
  logic [3:0]  tile;
  logic        bank_q;
  logic [23:0] recip_q;
  logic        phase_end;
  logic        sweep;

  assign phase_end = (cnt == 9'd257);
  assign sweep     = (state == S_CLIP) || (state == S_MAP);

  // ---------------- FSM ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FIRST;
      S_CLIP:  if (phase_end) state_nxt = S_MAP;
      S_MAP:   if (phase_end) state_nxt = (tile == 4'd15) ? S_FIN : S_FIRST;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 9'd0;
      tile    <= 4'd0;
      bank_q  <= 1'b0;
      recip_q <= 24'd0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (sweep && !phase_end) ? cnt + 9'd1 : 9'd0;
      done  <= (state == S_FIN);
      if (state == S_IDLE && start) begin
        bank_q  <= area_flag;
        recip_q <= tile_recip;
        tile    <= 4'd0;
      end else if (state == S_MAP && phase_end) begin
        tile <= tile + 4'd1;   // wraps to 0 after tile 15
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign rd_en    = sweep && !cnt[8];
  assign rd_addr  = cnt[7:0];
  assign rd_block = {bank_q, tile};

  // ---------------- read-return tags ----------------
  // Describe the data arriving on rd_data this cycle: which pass issued it,
  // which bin and which tile.
  logic       dv;
  logic       dv_map;
  logic [7:0] dv_addr;
  logic [3:0] dv_tile;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv      <= 1'b0;
      dv_map  <= 1'b0;
      dv_addr <= 8'd0;
      dv_tile <= 4'd0;
    end else begin
      dv      <= rd_en;
      dv_map  <= (state == S_MAP);
      dv_addr <= rd_addr;
      dv_tile <= tile;
    end
  end

  // The MAP read is the last read of a bin, so it is cleared as it returns.
  assign clr_en    = dv && dv_map;
  assign clr_addr  = dv_addr;
  assign clr_block = {bank_q, dv_tile};

  // ---------------- clipping ----------------
  logic [23:0] clipped;

`ifdef CLAHE_CLIP_EN
  logic [15:0] clip_q;
  logic [23:0] excess;
  logic [23:0] redist;
  logic [15:0] over;
  logic [15:0] capped;
  logic [23:0] excess_nxt;

  always_comb begin
    over       = (rd_data > clip_q) ? (rd_data - clip_q) : 16'd0;
    capped     = (rd_data > clip_q) ? clip_q : rd_data;
    // Bin 0 of a tile restarts the accumulator.
    excess_nxt = ((dv_addr == 8'd0) ? 24'd0 : excess) + {8'd0, over};
    clipped    = {8'd0, capped} + redist;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_q <= 16'd0;
      excess <= 24'd0;
      redist <= 24'd0;
    end else begin
      if (state == S_IDLE && start) clip_q <= clip_limit;
      if (dv && !dv_map) begin
        excess <= excess_nxt;
        // Latched on the last CLIP return so it is stable for the whole MAP
        // pass; the remainder of the division by 256 is dropped.
        if (dv_addr == 8'd255) redist <= excess_nxt >> 8;
      end
    end
  end
`else
  logic unused_clip;
  assign unused_clip = ^clip_limit;
  assign clipped     = {8'd0, rd_data};
`endif

  // ---------------- CDF and mapping ----------------
  logic [23:0] cdf;
  logic [23:0] cdf_nxt;
  logic [47:0] prod;
  logic [47:0] scaled;
  logic [7:0]  map_val;

  always_comb begin
    cdf_nxt = ((dv_addr == 8'd0) ? 24'd0 : cdf) + clipped;
    prod    = {24'd0, cdf_nxt} * {24'd0, recip_q};
    scaled  = prod >> 16;
    map_val = (scaled > 48'd255) ? 8'hFF : scaled[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdf       <= 24'd0;
      map_we    <= 1'b0;
      map_addr  <= 8'd0;
      map_block <= 4'd0;
      map_data  <= 8'd0;
    end else begin
      map_we <= dv && dv_map;
      if (dv && dv_map) begin
        cdf       <= cdf_nxt;
        map_addr  <= dv_addr;
        map_block <= dv_tile;
        map_data  <= map_val;
      end
    end
  end

endmodule
